// File: rtl/cmd_channel_arbiter_pkg.sv
// Shared encodings for the command-channel arbiter: idle/reset command codes, mode and state enums.
package cmd_channel_arbiter_pkg;

  localparam logic [7:0] NONACT = 8'h00;
  localparam logic [7:0] NONINT = 8'hFF;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_MAN  = 2'b01;
  localparam logic [1:0] GRANT_AUTO = 2'b10;

  typedef enum logic [1:0] {
    MODE_MAN    = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_SHARED = 2'b10,
    MODE_FREEZE = 2'b11
  } arb_mode_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_HOLD = 2'b01,
    ARB_GAP  = 2'b10,
    ARB_DONE = 2'b11
  } arb_state_e;

  function automatic logic [1:0] owner_onehot(input logic is_auto);
    return is_auto ? GRANT_AUTO : GRANT_MAN;
  endfunction

endpackage

// File: rtl/cmd_channel_arbiter_hold_gap_timer.sv
// Down-counter shared by the hold and gap phases; saturates at zero.
module hold_gap_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_r;

  // counter register: load has priority over decrement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/cmd_channel_arbiter.sv
// Grants the shared command channel to the manual or auto requester, holds the command,
// drives a no-action gap and pulses the owner's ack.
module cmd_channel_arbiter
  import cmd_channel_arbiter_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 2,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       m_req,
  input  logic [7:0] m_cmd,
  output logic       m_ack,
  input  logic       a_req,
  input  logic [7:0] a_cmd,
  output logic       a_ack,
  output logic [7:0] in_bits,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP_CYC == 0) ? '0 : CW'(GAP_CYC - 1);
  localparam logic          HAS_GAP = (GAP_CYC != 0);

  arb_state_e    state_r;
  logic          rr_last_auto_r;
  logic [7:0]    in_bits_r;
  logic [1:0]    grant_r;
  logic          busy_r;
  logic          m_ack_r;
  logic          a_ack_r;

  logic          elig_m_s;
  logic          elig_a_s;
  logic          pick_m_s;
  logic          pick_a_s;
  logic          tmr_load_s;
  logic [CW-1:0] tmr_val_s;
  logic          tmr_dec_s;
  logic          tmr_zero_s;

  // eligibility per mode and round-robin tie break (manual wins when auto went last)
  always_comb begin
    elig_m_s = 1'b0;
    elig_a_s = 1'b0;
    case (mode)
      MODE_MAN:    elig_m_s = m_req;
      MODE_AUTO:   elig_a_s = a_req;
      MODE_SHARED: begin
        elig_m_s = m_req;
        elig_a_s = a_req;
      end
      MODE_FREEZE: begin
        elig_m_s = 1'b0;
        elig_a_s = 1'b0;
      end
      default: begin
        elig_m_s = 1'b0;
        elig_a_s = 1'b0;
      end
    endcase
    pick_m_s = elig_m_s && (!elig_a_s || rr_last_auto_r);
    pick_a_s = elig_a_s && !pick_m_s;
  end

  // timer control derived from the current phase
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    tmr_dec_s  = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (pick_m_s || pick_a_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = HOLD_LD;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ARB_HOLD: begin
        if (tmr_zero_s) begin
          tmr_load_s = HAS_GAP;
          tmr_val_s  = GAP_LD;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ARB_GAP: begin
        if (tmr_zero_s) begin
          tmr_dec_s = 1'b0;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      default: begin
        tmr_load_s = 1'b0;
      end
    endcase
  end

  hold_gap_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // arbitration FSM with registered outputs; in_bits doubles as the command latch during HOLD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ARB_IDLE;
      rr_last_auto_r <= 1'b1;
      in_bits_r      <= NONINT;
      grant_r        <= GRANT_NONE;
      busy_r         <= 1'b0;
      m_ack_r        <= 1'b0;
      a_ack_r        <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          m_ack_r <= 1'b0;
          a_ack_r <= 1'b0;
          if (pick_m_s || pick_a_s) begin
            state_r   <= ARB_HOLD;
            in_bits_r <= pick_a_s ? a_cmd : m_cmd;
            grant_r   <= owner_onehot(pick_a_s);
            busy_r    <= 1'b1;
            if (elig_m_s && elig_a_s) begin
              rr_last_auto_r <= pick_a_s;
            end
          end else begin
            in_bits_r <= NONACT;
            grant_r   <= GRANT_NONE;
            busy_r    <= 1'b0;
          end
        end
        ARB_HOLD: begin
          if (tmr_zero_s) begin
            in_bits_r <= NONACT;
            if (HAS_GAP) begin
              state_r <= ARB_GAP;
            end else begin
              state_r <= ARB_DONE;
              grant_r <= GRANT_NONE;
              busy_r  <= 1'b0;
              m_ack_r <= grant_r[0];
              a_ack_r <= grant_r[1];
            end
          end
        end
        ARB_GAP: begin
          if (tmr_zero_s) begin
            state_r <= ARB_DONE;
            grant_r <= GRANT_NONE;
            busy_r  <= 1'b0;
            m_ack_r <= grant_r[0];
            a_ack_r <= grant_r[1];
          end
        end
        ARB_DONE: begin
          state_r <= ARB_IDLE;
          m_ack_r <= 1'b0;
          a_ack_r <= 1'b0;
        end
        default: begin
          state_r   <= ARB_IDLE;
          in_bits_r <= NONACT;
          grant_r   <= GRANT_NONE;
          busy_r    <= 1'b0;
          m_ack_r   <= 1'b0;
          a_ack_r   <= 1'b0;
        end
      endcase
    end
  end

  assign in_bits = in_bits_r;
  assign grant   = grant_r;
  assign busy    = busy_r;
  assign m_ack   = m_ack_r;
  assign a_ack   = a_ack_r;

endmodule

// File: tb/tb_cmd_channel_arbiter.sv
// Bench for cmd_channel_arbiter: two instances (4/2 and 1/0 hold/gap) checked against a schedule model.
module tb_cmd_channel_arbiter;
  import cmd_channel_arbiter_pkg::*;

  localparam int H0 = 4;
  localparam int G0 = 2;
  localparam int H1 = 1;
  localparam int G1 = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       m_req = 1'b0;
  logic       a_req = 1'b0;
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] a_cmd = 8'h00;

  logic [7:0] ib [2];
  logic [1:0] gr [2];
  logic       bz [2];
  logic       ma [2];
  logic       aa [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmd_channel_arbiter #(.HOLD_CYC(H0), .GAP_CYC(G0), .CW(8)) dut0 (
    .clk(clk), .rst(rst), .mode(mode),
    .m_req(m_req), .m_cmd(m_cmd), .m_ack(ma[0]),
    .a_req(a_req), .a_cmd(a_cmd), .a_ack(aa[0]),
    .in_bits(ib[0]), .grant(gr[0]), .busy(bz[0])
  );

  cmd_channel_arbiter #(.HOLD_CYC(H1), .GAP_CYC(G1), .CW(8)) dut1 (
    .clk(clk), .rst(rst), .mode(mode),
    .m_req(m_req), .m_cmd(m_cmd), .m_ack(ma[1]),
    .a_req(a_req), .a_cmd(a_cmd), .a_ack(aa[1]),
    .in_bits(ib[1]), .grant(gr[1]), .busy(bz[1])
  );

  // Reference model: position in the command schedule counted from the grant edge.
  // 0 = idle, 1..H = command, H+1..H+G = gap, H+G+1 = ack cycle.
  int         pos [2];
  int         own [2];       // 0 none, 1 manual, 2 auto
  logic [7:0] lcmd [2];
  logic       rr_auto [2];   // auto was the last tie winner
  logic       fresh [2];     // no clock edge since reset

  function automatic int hold_of(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    pos[i] = 0; own[i] = 0; lcmd[i] = 8'h00; rr_auto[i] = 1'b1; fresh[i] = 1'b1;
  endtask

  task automatic model_edge(input int i);
    logic em;
    logic ea;
    fresh[i] = 1'b0;
    if (pos[i] == 0) begin
      em = ((mode == 2'd0) || (mode == 2'd2)) && m_req;
      ea = ((mode == 2'd1) || (mode == 2'd2)) && a_req;
      if (em && ea) begin
        own[i] = rr_auto[i] ? 1 : 2;
        rr_auto[i] = (own[i] == 2);
      end else if (em) own[i] = 1;
      else if (ea) own[i] = 2;
      else own[i] = 0;
      if (own[i] != 0) begin
        pos[i] = 1;
        lcmd[i] = (own[i] == 1) ? m_cmd : a_cmd;
      end
    end else if (pos[i] == hold_of(i) + gap_of(i) + 1) begin
      pos[i] = 0;
      own[i] = 0;
    end else begin
      pos[i]++;
    end
  endtask

  task automatic model_check(input int i);
    int h;
    int g;
    int e_ib;
    int e_gr;
    int e_bz;
    int e_ma;
    int e_aa;
    string p;
    h = hold_of(i); g = gap_of(i);
    p = (i == 0) ? "d0" : "d1";
    e_ib = NONACT; e_gr = 0; e_bz = 0; e_ma = 0; e_aa = 0;
    if (pos[i] == 0) begin
      e_ib = fresh[i] ? NONINT : NONACT;
    end else if (pos[i] <= h) begin
      e_ib = lcmd[i]; e_gr = own[i]; e_bz = 1;
    end else if (pos[i] <= h + g) begin
      e_gr = own[i]; e_bz = 1;
    end else begin
      e_ma = (own[i] == 1) ? 1 : 0;
      e_aa = (own[i] == 2) ? 1 : 0;
    end
    chk({p, ".in_bits"}, ib[i], e_ib);
    chk({p, ".grant"}, gr[i], e_gr);
    chk({p, ".busy"}, bz[i], e_bz);
    chk({p, ".m_ack"}, ma[i], e_ma);
    chk({p, ".a_ack"}, aa[i], e_aa);
    chk({p, ".grant_is_11"}, (gr[i] == 2'b11) ? 1 : 0, 0);
    chk({p, ".ack_overlap"}, (ma[i] && aa[i]) ? 1 : 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) model_reset(i);
      else model_edge(i);
    end
    #1;
    for (int i = 0; i < 2; i++) model_check(i);
  endtask

  task automatic assert_rst();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      model_check(i);
    end
  endtask

  task automatic do_reset();
    assert_rst();
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       m_req;
    logic [7:0] m_cmd;
    logic [7:0] e_ib;
    logic [1:0] e_gr;
    logic       e_bz;
    logic       e_ma;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [1:0] q [$];
    logic [1:0] prev;
    int acks;
    int late;
    int seen;
    int r;

    tbl[0] = '{2'd0, 1'b1, 8'h27, 8'h27,  2'b01, 1'b1, 1'b0};
    tbl[1] = '{2'd0, 1'b1, 8'h27, 8'h27,  2'b01, 1'b1, 1'b0};
    tbl[2] = '{2'd0, 1'b1, 8'h27, 8'h27,  2'b01, 1'b1, 1'b0};
    tbl[3] = '{2'd0, 1'b1, 8'h27, 8'h27,  2'b01, 1'b1, 1'b0};
    tbl[4] = '{2'd0, 1'b1, 8'h27, NONACT, 2'b01, 1'b1, 1'b0};
    tbl[5] = '{2'd0, 1'b1, 8'h27, NONACT, 2'b01, 1'b1, 1'b0};
    tbl[6] = '{2'd0, 1'b1, 8'h27, NONACT, 2'b00, 1'b0, 1'b1};
    tbl[7] = '{2'd0, 1'b0, 8'h27, NONACT, 2'b00, 1'b0, 1'b0};
    tbl[8] = '{2'd0, 1'b0, 8'h27, NONACT, 2'b00, 1'b0, 1'b0};

    #2;
    do_reset();
    chk("reset.in_bits", ib[0], NONINT);

    // Basic manual command, cycle-by-cycle vectors
    for (int k = 0; k < 9; k++) begin
      mode = tbl[k].mode; m_req = tbl[k].m_req; m_cmd = tbl[k].m_cmd; a_req = 1'b0;
      step();
      chk($sformatf("vec%0d.in_bits", k), ib[0], tbl[k].e_ib);
      chk($sformatf("vec%0d.grant", k), gr[0], tbl[k].e_gr);
      chk($sformatf("vec%0d.busy", k), bz[0], tbl[k].e_bz);
      chk($sformatf("vec%0d.m_ack", k), ma[0], tbl[k].e_ma);
    end

    // Shared mode with both requests held: grants alternate starting with manual
    do_reset();
    mode = 2'd2; m_req = 1'b1; a_req = 1'b1; m_cmd = 8'h11; a_cmd = 8'h22;
    prev = 2'b00;
    for (int k = 0; k < 40; k++) begin
      step();
      if (prev == 2'b00 && gr[0] != 2'b00) q.push_back(gr[0]);
      prev = gr[0];
    end
    chk("rr.grant_count_ge3", (q.size() >= 3) ? 1 : 0, 1);
    if (q.size() >= 3) begin
      chk("rr.first", q[0], 2'b01);
      chk("rr.second", q[1], 2'b10);
      chk("rr.third", q[2], 2'b01);
    end

    // Auto command changed after grant is ignored
    do_reset();
    mode = 2'd1; m_req = 1'b0; a_req = 1'b1; a_cmd = 8'h4B;
    step();
    a_cmd = 8'h0B;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("auto_hold%0d.in_bits", k), ib[0], 8'h4B);
      chk($sformatf("auto_hold%0d.grant", k), gr[0], 2'b10);
      step();
    end
    a_req = 1'b0;
    step();
    step();
    chk("auto.a_ack", aa[0], 1);

    // Freeze while busy: in-flight command completes, no further grants
    do_reset();
    mode = 2'd0; m_req = 1'b1; a_req = 1'b1; m_cmd = 8'h33; a_cmd = 8'h44;
    step();
    step();
    mode = 2'd3;
    acks = 0; late = 0; seen = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (seen != 0 && gr[0] != 2'b00) late++;
      if (ma[0]) begin
        acks++;
        seen = 1;
      end
    end
    chk("freeze.m_ack_count", acks, 1);
    chk("freeze.late_grants", late, 0);

    // Hold 1 / gap 0 instance: command one cycle, ack next, re-grant after idle arbitration
    do_reset();
    mode = 2'd0; m_req = 1'b1; a_req = 1'b0; m_cmd = 8'h5A;
    step();
    chk("short.cmd", ib[1], 8'h5A);
    chk("short.grant", gr[1], 2'b01);
    step();
    chk("short.m_ack", ma[1], 1);
    chk("short.grant_done", gr[1], 2'b00);
    step();
    chk("short.idle_grant", gr[1], 2'b00);
    step();
    chk("short.regrant_cmd", ib[1], 8'h5A);
    chk("short.regrant", gr[1], 2'b01);

    // Reset during HOLD: outputs return at once, no ack, manual re-grants after release
    do_reset();
    mode = 2'd0; m_req = 1'b1; a_req = 1'b0; m_cmd = 8'h6C;
    step();
    step();
    assert_rst();
    chk("rst_mid.in_bits", ib[0], NONINT);
    chk("rst_mid.grant", gr[0], 2'b00);
    chk("rst_mid.m_ack", ma[0], 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_mid.regrant", gr[0], 2'b01);
    chk("rst_mid.regrant_cmd", ib[0], 8'h6C);

    // Randomized traffic against the schedule model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 9);
      mode = (r < 5) ? 2'd2 : (r < 7) ? 2'd0 : (r < 9) ? 2'd1 : 2'd3;
      m_req = ($urandom_range(0, 3) != 0);
      a_req = ($urandom_range(0, 3) != 0);
      m_cmd = 8'($urandom);
      a_cmd = 8'($urandom);
      if ($urandom_range(0, 199) == 0) assert_rst();
      else rst = 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
